// File: rtl/ai_cache_pkg.sv
// Shared types and width helpers for the set-associative accelerator line cache.
package ai_cache_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INVAL = 2'd2,
    OP_FLUSH = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_sets);
    return addr_w - $clog2(num_sets);
  endfunction

  function automatic int age_w(input int num_ways);
    return $clog2(num_ways);
  endfunction

endpackage

// File: rtl/ai_cache_sa_if.sv
// Request/response handshake bundle between the tensor load unit and the cache.
interface ai_cache_sa_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_hit;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_evict;
  logic [CNT_WIDTH-1:0]  hit_count;
  logic [CNT_WIDTH-1:0]  miss_count;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_rdata, rsp_evict, hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_rdata, rsp_evict, hit_count, miss_count
  );
endinterface

// File: rtl/ai_cache_lru.sv
// Per-set true-LRU: age update on touch and victim choice (first invalid, else oldest).
module ai_cache_lru
  import ai_cache_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int AGE_W    = age_w(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][AGE_W-1:0] ages_i,
  input  logic [NUM_WAYS-1:0]            valid_i,
  input  logic [AGE_W-1:0]               touch_way_i,
  input  logic                           touch_en_i,
  output logic [NUM_WAYS-1:0][AGE_W-1:0] ages_o,
  output logic [AGE_W-1:0]               victim_o
);

  always_comb begin
    ages_o = ages_i;
    if (touch_en_i) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (AGE_W'(w) == touch_way_i) begin
          ages_o[w] = '0;
        end else if (ages_i[w] < ages_i[touch_way_i]) begin
          ages_o[w] = ages_i[w] + AGE_W'(1);
        end
      end
    end
  end

  logic found;

  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        victim_o = AGE_W'(w);
        found    = 1'b1;
      end
    end
    // Ages form a permutation, so exactly one way holds the oldest age.
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (ages_i[w] == AGE_W'(NUM_WAYS - 1)) victim_o = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/ai_cache_sa.sv
// Set-associative line cache: single-edge lookup/update, sequential flush, hit/miss stats.
// state    | meaning
// ST_IDLE  | accepting requests, response register may be pending
// ST_FLUSH | invalidating one set per cycle, requests blocked
module ai_cache_sa
  import ai_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SETS   = 256,
  parameter int NUM_WAYS   = 4,
  parameter int CNT_WIDTH  = 32
) (
  input logic          clk,
  input logic          reset,
  ai_cache_sa_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_WIDTH, NUM_SETS);
  localparam int AGE_W = age_w(NUM_WAYS);

  typedef logic [NUM_WAYS-1:0][AGE_W-1:0] ages_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
  logic             flush_done;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  ages_t                 age_q   [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic                  rsp_valid_q, rsp_hit_q, rsp_evict_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q;

  op_e                 op;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                req_ready, accept;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit_any;
  logic [AGE_W-1:0]    hit_way, victim, touch_way;
  logic                touch_en;
  ages_t               ages_next, ages_init;

  assign op        = op_e'(bus.req_op);
  assign idx       = bus.req_addr[IDX_W-1:0];
  assign tag       = bus.req_addr[ADDR_WIDTH-1:IDX_W];
  assign req_ready = (state_q == ST_IDLE) && (!rsp_valid_q || bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    ages_init = '0;
    for (int w = 0; w < NUM_WAYS; w++) ages_init[w] = AGE_W'(w);
  end

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (hit_vec[w]) hit_way = AGE_W'(w);
    end
  end

  assign hit_any   = |hit_vec;
  assign touch_way = hit_any ? hit_way : victim;
  assign touch_en  = accept && ((op == OP_READ && hit_any) || op == OP_WRITE);

  ai_cache_lru #(
    .NUM_WAYS (NUM_WAYS),
    .AGE_W    (AGE_W)
  ) u_lru (
    .ages_i      (age_q[idx]),
    .valid_i     (valid_q[idx]),
    .touch_way_i (touch_way),
    .touch_en_i  (touch_en),
    .ages_o      (ages_next),
    .victim_o    (victim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    flush_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && op == OP_FLUSH) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
        end
      end
      ST_FLUSH: begin
        flush_idx_d = flush_idx_q + IDX_W'(1);
        if (flush_idx_q == '1) begin
          state_d    = ST_IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= ages_init;
      end
    end else if (state_q == ST_FLUSH) begin
      valid_q[flush_idx_q] <= '0;
      age_q[flush_idx_q]   <= ages_init;
    end else if (accept) begin
      age_q[idx] <= ages_next;
      if (op == OP_WRITE && !hit_any) valid_q[idx][victim] <= 1'b1;
      if (op == OP_INVAL && hit_any)  valid_q[idx][hit_way] <= 1'b0;
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (accept && op == OP_WRITE) begin
      tag_q[idx][touch_way]  <= tag;
      data_q[idx][touch_way] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_evict_q <= 1'b0;
    end else if (accept && op == OP_FLUSH) begin
      rsp_valid_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_hit_q   <= hit_any;
      rsp_rdata_q <= (op == OP_READ && hit_any) ? data_q[idx][hit_way] : '0;
      rsp_evict_q <= (op == OP_WRITE) && !hit_any && valid_q[idx][victim];
    end else if (flush_done) begin
      rsp_valid_q <= 1'b1;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_evict_q <= 1'b0;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept && (op == OP_READ || op == OP_WRITE)) begin
      if (hit_any && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + CNT_WIDTH'(1);
      if (!hit_any && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_evict  = rsp_evict_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_ai_cache_sa.sv
// Bench for ai_cache_sa: directed table, flush/back-pressure/reset sequences, random vs recency-list model.
module tb_ai_cache_sa;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, IV = 2'd2, FL = 2'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ai_cache_sa_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CNT_WIDTH(8)) bus ();

  ai_cache_sa #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .NUM_SETS   (NS),
    .NUM_WAYS   (NW),
    .CNT_WIDTH  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: per-set recency list (position 0 = most recent) plus line contents.
  logic        m_valid [NS][NW];
  int          m_tag   [NS][NW];
  logic [31:0] m_data  [NS][NW];
  int          m_rank  [NS][NW];
  int          m_hitc, m_missc;

  function automatic void model_flush();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < NW; k++) begin
        m_valid[s][k] = 1'b0;
        m_rank[s][k]  = k;
      end
  endfunction

  function automatic void model_reset();
    model_flush();
    m_hitc  = 0;
    m_missc = 0;
  endfunction

  function automatic void m_touch(int s, int w);
    int p = 0;
    for (int k = 0; k < NW; k++) if (m_rank[s][k] == w) p = k;
    for (int k = p; k > 0; k--) m_rank[s][k] = m_rank[s][k-1];
    m_rank[s][0] = w;
  endfunction

  function automatic logic [63:0] sat(int c);
    return (c > 255) ? 64'd255 : 64'(c);
  endfunction

  task automatic model_access(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd,
                              output logic eh, output logic [31:0] ed, output logic ee);
    int s = int'(addr) % NS;
    int t = int'(addr) / NS;
    int hw = -1;
    int v = -1;
    eh = 1'b0; ed = '0; ee = 1'b0;
    for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (op == RD) begin
      if (hw >= 0) begin eh = 1'b1; ed = m_data[s][hw]; m_touch(s, hw); m_hitc++; end
      else m_missc++;
    end else if (op == WR) begin
      if (hw >= 0) begin
        eh = 1'b1; m_data[s][hw] = wd; m_touch(s, hw); m_hitc++;
      end else begin
        for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) begin v = m_rank[s][NW-1]; ee = 1'b1; end
        m_valid[s][v] = 1'b1; m_tag[s][v] = t; m_data[s][v] = wd;
        m_touch(s, v); m_missc++;
      end
    end else if (op == IV) begin
      if (hw >= 0) begin eh = 1'b1; m_valid[s][hw] = 1'b0; end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rsp(input string nm, input logic eh, input logic [31:0] ed, input logic ee,
                         input logic [63:0] ehc, input logic [63:0] emc);
    chk({nm, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({nm, ".hit"},       64'(bus.rsp_hit), 64'(eh));
    chk({nm, ".rdata"},     64'(bus.rsp_rdata), 64'(ed));
    chk({nm, ".evict"},     64'(bus.rsp_evict), 64'(ee));
    chk({nm, ".hit_count"}, 64'(bus.hit_count), ehc);
    chk({nm, ".miss_count"},64'(bus.miss_count), emc);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    while (!bus.req_ready) begin
      if (n == 50) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: req_ready 0 after %0d cycles, required 1", n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "request never accepted");
      end
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_flush();
    issue(FL, 8'h00, 32'h0);
    for (int k = 1; k <= NS; k++) begin
      @(negedge clk);
      chk("flush_busy_ready", 64'(bus.req_ready), 64'd0);
      chk("flush_busy_valid", 64'(bus.rsp_valid), 64'd0);
    end
    @(negedge clk);
    model_flush();
    chk_rsp("flush_rsp", 1'b0, 32'h0, 1'b0, sat(m_hitc), sat(m_missc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("reset_async_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    model_reset();
    #1;
    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_hit_count", 64'(bus.hit_count), 64'd0);
    chk("reset_miss_count", 64'(bus.miss_count), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] rd;
    logic        ev;
    int          hc;
    int          mc;
  } vec_t;

  vec_t vecs [20];

  initial begin
    logic        eh, ee;
    logic [31:0] ed;

    vecs[0]  = '{RD, 8'h10, 32'h00, 1'b0, 32'h00, 1'b0, 0, 1};
    vecs[1]  = '{WR, 8'h10, 32'hAA, 1'b0, 32'h00, 1'b0, 0, 2};
    vecs[2]  = '{RD, 8'h10, 32'h00, 1'b1, 32'hAA, 1'b0, 1, 2};
    vecs[3]  = '{IV, 8'h10, 32'h00, 1'b1, 32'h00, 1'b0, 1, 2};
    vecs[4]  = '{RD, 8'h10, 32'h00, 1'b0, 32'h00, 1'b0, 1, 3};
    vecs[5]  = '{IV, 8'h10, 32'h00, 1'b0, 32'h00, 1'b0, 1, 3};
    vecs[6]  = '{WR, 8'h00, 32'h01, 1'b0, 32'h00, 1'b0, 1, 4};
    vecs[7]  = '{WR, 8'h04, 32'h02, 1'b0, 32'h00, 1'b0, 1, 5};
    vecs[8]  = '{RD, 8'h00, 32'h00, 1'b1, 32'h01, 1'b0, 2, 5};
    vecs[9]  = '{WR, 8'h08, 32'h03, 1'b0, 32'h00, 1'b1, 2, 6};
    vecs[10] = '{RD, 8'h04, 32'h00, 1'b0, 32'h00, 1'b0, 2, 7};
    vecs[11] = '{RD, 8'h00, 32'h00, 1'b1, 32'h01, 1'b0, 3, 7};
    vecs[12] = '{RD, 8'h08, 32'h00, 1'b1, 32'h03, 1'b0, 4, 7};
    vecs[13] = '{IV, 8'h00, 32'h00, 1'b1, 32'h00, 1'b0, 4, 7};
    vecs[14] = '{RD, 8'h00, 32'h00, 1'b0, 32'h00, 1'b0, 4, 8};
    vecs[15] = '{IV, 8'h00, 32'h00, 1'b0, 32'h00, 1'b0, 4, 8};
    vecs[16] = '{WR, 8'h08, 32'h33, 1'b1, 32'h00, 1'b0, 5, 8};
    vecs[17] = '{RD, 8'h08, 32'h00, 1'b1, 32'h33, 1'b0, 6, 8};
    vecs[18] = '{WR, 8'h05, 32'h55, 1'b0, 32'h00, 1'b0, 6, 9};
    vecs[19] = '{RD, 8'h05, 32'h00, 1'b1, 32'h55, 1'b0, 7, 9};

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = RD;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_hit",   64'(bus.rsp_hit), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_rsp_evict", 64'(bus.rsp_evict), 64'd0);
    chk("rst_hit_count", 64'(bus.hit_count), 64'd0);
    chk("rst_miss_count",64'(bus.miss_count), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].op, vecs[i].addr, vecs[i].wd);
      model_access(vecs[i].op, vecs[i].addr, vecs[i].wd, eh, ed, ee);
      chk_rsp($sformatf("vec%0d", i), vecs[i].hit, vecs[i].rd, vecs[i].ev,
              64'(vecs[i].hc), 64'(vecs[i].mc));
    end

    do_flush();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = (i == 0) ? 8'h05 : (i == 1) ? 8'h08 : (i == 2) ? 8'h00 : 8'h10;
      issue(RD, a, 32'h0);
      model_access(RD, a, 32'h0, eh, ed, ee);
      chk_rsp("post_flush_read", 1'b0, 32'h0, 1'b0, sat(m_hitc), sat(m_missc));
    end

    // Back-pressure: response must hold while rsp_ready is low.
    issue(WR, 8'h01, 32'h77);
    model_access(WR, 8'h01, 32'h77, eh, ed, ee);
    chk_rsp("bp_write", eh, ed, ee, sat(m_hitc), sat(m_missc));
    @(posedge clk); #1;
    chk("bp_drained", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 1'b0;
    issue(RD, 8'h01, 32'h0);
    model_access(RD, 8'h01, 32'h0, eh, ed, ee);
    chk_rsp("bp_read", 1'b1, 32'h77, 1'b0, sat(m_hitc), sat(m_missc));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_hold_hit",   64'(bus.rsp_hit), 64'd1);
      chk("bp_hold_rdata", 64'(bus.rsp_rdata), 64'h77);
    end
    do_reset();

    issue(WR, 8'h01, 32'h99);
    model_access(WR, 8'h01, 32'h99, eh, ed, ee);
    chk_rsp("pre_abort_write", eh, ed, ee, sat(m_hitc), sat(m_missc));
    issue(FL, 8'h00, 32'h0);
    @(negedge clk); @(negedge clk);
    do_reset();
    issue(RD, 8'h01, 32'h0);
    model_access(RD, 8'h01, 32'h0, eh, ed, ee);
    chk_rsp("post_abort_read", 1'b0, 32'h0, 1'b0, sat(m_hitc), sat(m_missc));

    do_reset();
    for (int i = 0; i < 700; i++) begin
      int r;
      logic [1:0]  op;
      logic [7:0]  a;
      logic [31:0] wd;
      r  = int'($urandom_range(0, 99));
      a  = 8'($urandom_range(0, 23));
      wd = $urandom;
      op = (r < 40) ? RD : (r < 80) ? WR : (r < 98) ? IV : FL;
      if (op == FL) begin
        do_flush();
      end else begin
        issue(op, a, wd);
        model_access(op, a, wd, eh, ed, ee);
        chk_rsp("rnd", eh, ed, ee, sat(m_hitc), sat(m_missc));
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ai_cache_sa.md
# ai_cache_sa

Set-associative successor to the direct-mapped AI-accelerator line cache. It is parametrised in sets, ways and widths, and splits each address into index and tag. It uses true-LRU replacement, valid/ready request and response handshakes, per-line invalidate, whole-cache flush, and saturating hit/miss counters. It sits between the accelerator's tensor load unit and the on-chip buffer and holds whole DATA_WIDTH words with no backing-store traffic: misses report, they do not fetch.

## Interface
- ADDR_WIDTH, 32, word address width.
- DATA_WIDTH, 128, line/word width.
- NUM_SETS, 256, number of sets; power of two, ≥2.
- NUM_WAYS, 4, associativity; power of two, 2..8.
- CNT_WIDTH, 32, statistics counter width.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  2  0 READ, 1 WRITE, 2 INVAL (one address), 3 FLUSH (all).
- req_addr  in  ADDR_WIDTH  word address; index = addr[IDX_W-1:0], tag = addr[ADDR_WIDTH-1:IDX_W], IDX_W = clog2(NUM_SETS).
- req_wdata  in  DATA_WIDTH  write data (WRITE only).
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_hit  out  1  tag matched a valid way (READ/WRITE/INVAL); 0 for FLUSH.
- rsp_rdata  out  DATA_WIDTH  READ hit data; 0 otherwise.
- rsp_evict  out  1  WRITE miss replaced a valid line.
- hit_count, miss_count  out  CNT_WIDTH  statistics.

## Operation
- States: IDLE, FLUSH. req_ready = (state==IDLE) && (!rsp_valid || rsp_ready), combinational.
- On accept in IDLE, all lookup and array updates happen on that edge. The response registers on the same edge.
- READ hit:
  - rdata = way data; hit=1.
  - The way becomes MRU.
- READ miss: rdata=0, hit=0, no allocation, LRU unchanged.
- WRITE hit: overwrite data in the hit way; hit=1; way becomes MRU.
- WRITE miss:
  - Victim is the lowest-index invalid way; if none, the LRU way. evict=1 iff the victim was valid.
  - Write tag/data, set valid, and make the victim MRU.
- INVAL: clear valid of the matching way; hit=1 if one existed. LRU unchanged.
- FLUSH:
  - Go to FLUSH and clear valid of all ways in one set per cycle, index 0..NUM_SETS-1, resetting the set's ages to way order.
  - After the last set, return to IDLE and raise rsp_valid with hit=0.
  - req_ready=0 throughout.
- LRU: per-way age of clog2(NUM_WAYS) bits. On touch, the touched way's age goes to 0 and ways younger than it increment. LRU is the way with age NUM_WAYS-1. Reset/flush ages are age[w]=w.
- Counters: hit_count++ on READ/WRITE hit; miss_count++ on READ/WRITE miss. Both saturate at all-ones. INVAL/FLUSH do not count.
- Tag match never considers invalid ways. At most one way matches by construction.

## Timing
- Reset values:
  - state IDLE; all valid=0; ages = way order; rsp_valid=0, rsp_hit=0, rsp_rdata=0, rsp_evict=0; counters 0.
  - Data arrays are not reset.
- Latency: the response is visible one cycle after accept. Throughput is 1 request/cycle while rsp_ready=1.
- Back-pressure: with rsp_valid && !rsp_ready, req_ready=0 and all response fields are stable.
- Back-to-back same address: the second request observes the first's update (write-then-read hits with new data).
- FLUSH takes NUM_SETS cycles after accept; rsp_valid rises NUM_SETS+1 cycles after accept.
- Reset mid-flush or with a pending response aborts immediately. The response is dropped and all lines are invalid.

## Structure
- Package ai_cache_pkg holds:
  - op enum (READ/WRITE/INVAL/FLUSH) and state enum;
  - helpers for IDX_W/TAG_W/AGE_W derivation.
- Sub-module ai_cache_lru: combinational per-set age update and victim select (inputs: ages, valids, touched way, touch enable; outputs: next ages, victim way).
- Top holds arrays, FSM, response register and counters.

## Test plan
- Configuration for directed tests is NUM_SETS=4, NUM_WAYS=2.
- Reset, then READ 0x10: response after 1 cycle with hit=0, rdata=0, miss_count=1.
- WRITE 0x10=0xAA, then READ 0x10 back-to-back: second response hit=1, rdata=0xAA, hit_count=1.
- Set-0 conflict, ages showing LRU choice:
  - Stimulus: WRITE 0x0, 0x4, READ 0x0, then WRITE 0x8.
  - Response: the WRITE 0x8 has evict=1; READ 0x4 then misses, READ 0x0 hits.
- INVAL 0x0 → hit=1; READ 0x0 → hit=0; INVAL 0x0 again → hit=0.
- Fill lines, FLUSH:
  - req_ready=0 for 4 cycles, rsp_valid at cycle 5 with hit=0.
  - All subsequent READs miss.
- Hold rsp_ready=0 for 3 cycles: response stable and req_ready=0. Then assert reset mid-FLUSH: rsp_valid=0 and all lines invalid.
